move_sequencer: RTL
===================

# move_sequencer

Command sequencer between the SPI word handler and the stepper step generator. It parses 32-bit little-endian command words into configuration updates and coordinated-move records, and buffers moves in a small FIFO. It dispatches buffered moves one at a time to the step generator using a start/done handshake. This replaces ad-hoc word decoding with a single clocked controller that owns all stepper configuration state.

## Interface
- `DEPTH`, default 4: move FIFO entries; a power of two, at least 2.
- `DIV_RESET`, default 32: reset value of `clock_divisor`.
- `CLK` input, 1 bit: system clock, 16 MHz.
- `reset` input, 1 bit: synchronous, active-high reset.
- `word_valid` input, 1 bit: single-cycle pulse, synchronous to `CLK`; `word_data` is valid in that cycle.
- `word_data` input, 32 bits: received command word.
- `move_busy` input, 1 bit: step generator is executing a move.
- `move_done` input, 1 bit: single-cycle pulse at the end of a move.
- `move_start` output, 1 bit: single-cycle pulse that launches a move.
- `move_duration` output, 32 bits: tick count of the dispatched move.
- `increment` output, 32 bits, signed: increment of the dispatched move.
- `incrementincrement` output, 32 bits, signed: second-order increment of the dispatched move.
- `dir` output, 1 bit: direction of the dispatched move.
- `clock_divisor` output, 24 bits: tick divisor.
- `microsteps` output, 3 bits: microstep setting.
- `fifo_count` output, $clog2(DEPTH)+1 bits: number of buffered moves.
- `status` output, 3 bits: sticky flags; bit 0 overflow, bit 1 unknown header, bit 2 bad microstep.

## Operation
- **Header decode:** in parser state IDLE, the header is `word_data[31:24]`.
  - 0x01 (move): latch `dir` = `word_data[0]`, then go to P1.
  - 0x03: `clock_divisor` ← `word_data[23:0]`.
  - 0x04: `microsteps` ← `word_data[2:0]` only if the value is 1, 2 or 4. Any other value sets `status[2]` and leaves `microsteps` unchanged.
  - 0x05: flush the FIFO. Sets `fifo_count` to 0. The move currently executing is unaffected.
  - 0x06: clear `status`.
  - Any other header sets `status[1]`; the word is dropped.
- **Move payload:** P1 latches the duration, P2 latches the increment, P3 latches incrementincrement, then the parser returns to IDLE.
  - At P3 the assembled record {dir, duration, inc, incinc} is pushed to the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the record is dropped and `status[0]` is set.
- **Dispatcher FSM, states D_IDLE and D_RUN:**
  - D_IDLE → D_RUN when `fifo_count` > 0 and `move_busy`=0. In that transition: pop the head record, register it onto the move outputs, and pulse `move_start`.
  - D_RUN → D_IDLE on `move_done`.
  - `move_done` is ignored in D_IDLE.
- **Move outputs:** hold their values from one `move_start` until the next.
- **Simultaneous events:**
  - Push and pop in the same cycle: `fifo_count` is unchanged. A push into a full FIFO succeeds when a pop occurs in that cycle.
  - Flush and pop in the same cycle: the pop wins for the head entry; all other entries are discarded.
  - Flush and push in the same cycle: this cannot occur, because only one word is processed per cycle.
- **Pointers:** wrap modulo DEPTH. `fifo_count` saturates at DEPTH, never wraps.

## Timing
- **Reset values:**
  - `move_start`, `dir`, `move_duration`, `increment`, `incrementincrement`: 0.
  - `clock_divisor`: DIV_RESET.
  - `microsteps`: 1.
  - `fifo_count`: 0; `status`: 0.
  - Parser in IDLE; dispatcher in D_IDLE.
- **Reset mid-operation:** discards any partial message and all FIFO contents. The step generator's own state is outside this block.
- **Config latency:** a config word on cycle N is visible on its output at N+1.
- **Move latency:** third payload word on cycle N:
  - `fifo_count` increments at N+1.
  - With the dispatcher idle and `move_busy`=0, `move_start` is high during N+2 and the move outputs are valid from N+2.
- **Back-to-back moves:** `move_done` on cycle M allows `move_start` no earlier than M+2, gated by `move_busy` falling.
- **Throughput:** one word per cycle is accepted indefinitely; there is no backpressure on `word_valid`.

## Structure
- **Package `rap_pkg`:**
  - Header constants `HDR_MOVE`=0x01, `HDR_DIV`=0x03, `HDR_USTEP`=0x04, `HDR_FLUSH`=0x05, `HDR_CLR`=0x06.
  - Typedef `move_t` {dir, duration[31:0], inc[31:0], incinc[31:0]}, 97 bits.
  - Parser and dispatcher state enums.
- **Sub-module `move_fifo`:** synchronous single-clock FIFO of `move_t`, parameter DEPTH. Ports: push, pop, flush, full, empty, count. Both FSMs stay in `move_sequencer`.

## Test plan
- **Reset defaults:** assert `reset` → all outputs hold their reset values; `clock_divisor`=32, `microsteps`=1.
- **Single move:** words 0x01000001, 0x00001000, 0x00000064, 0x00000001 on consecutive cycles with `move_busy`=0 → `move_start` pulses exactly 2 cycles after the last word, with `dir`=1, duration 0x1000, inc 100, incinc 1.
- **Queued moves:** 5 moves with DEPTH=4 while `move_busy`=1 → `fifo_count`=4 and `status[0]`=1. Then 4 `move_done`/`move_busy` cycles → 4 starts in FIFO order, and `fifo_count` returns to 0.
- **Config words:** 0x04000003 → `microsteps` stays 1 and `status[2]`=1. 0x04000004 → `microsteps`=4. 0x030000FF → `clock_divisor`=0xFF one cycle later.
- **Flush, unknown header, reset:**
  - Flush during a run with 3 queued moves → `fifo_count`=0 and no further `move_start`.
  - Header 0x7F → `status[1]`=1.
  - `reset` after move word P2 → parser in IDLE; the next word 0x03000010 is decoded as a config word.

Source files
------------

// File: rtl/rap_pkg.sv
// Shared types and constants for the move sequencer: command headers,
// the buffered move record, and the parser/dispatcher state encodings.
package rap_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DIV_W    = 24;
  localparam int unsigned USTEP_W  = 3;
  localparam int unsigned STATUS_W = 3;
  localparam int unsigned HDR_W    = 8;

  localparam logic [HDR_W-1:0] HDR_MOVE  = 8'h01;
  localparam logic [HDR_W-1:0] HDR_DIV   = 8'h03;
  localparam logic [HDR_W-1:0] HDR_USTEP = 8'h04;
  localparam logic [HDR_W-1:0] HDR_FLUSH = 8'h05;
  localparam logic [HDR_W-1:0] HDR_CLR   = 8'h06;

  // One coordinated move as dispatched to the step generator (97 bits)
  typedef struct packed {
    logic                     dir;
    logic [WORD_W-1:0]        duration;
    logic signed [WORD_W-1:0] inc;
    logic signed [WORD_W-1:0] incinc;
  } move_t;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_1    = 2'd1,
    P_2    = 2'd2,
    P_3    = 2'd3
  } parser_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_RUN  = 1'b1
  } disp_state_t;

  // Only full, half and quarter stepping are supported by the driver
  function automatic logic ustep_valid(input logic [USTEP_W-1:0] v);
    return (v == 3'd1) || (v == 3'd2) || (v == 3'd4);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Single-clock FIFO of move records.
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_push, i_wr_data  : write request and record
//   i_pop              : read request (head is consumed at the edge)
//   i_flush            : discard everything except a head popped this cycle
//   o_rd_data_c        : current head record (combinational from storage)
//   o_full, o_empty    : registered occupancy flags
//   o_count            : registered number of stored records, saturates at DEPTH
module move_fifo
  import rap_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  move_t                    i_wr_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output move_t                    o_rd_data_c,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  move_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_rd_data_c = r_mem[r_rd_ptr];

  // Next pointers/count; a push into a full FIFO only lands if a pop frees a slot
  always_comb begin
    w_pop_ok     = i_pop && !o_empty;
    w_push_ok    = i_push && !i_flush && (!o_full || w_pop_ok);
    w_rd_ptr_nxt = w_pop_ok  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_wr_ptr_nxt = w_push_ok ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    w_count_nxt  = o_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    // Flush keeps a same-cycle pop, then empties by collapsing write onto read
    if (i_flush) begin
      w_wr_ptr_nxt = w_rd_ptr_nxt;
      w_count_nxt  = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      o_count  <= '0;
      o_full   <= 1'b0;
      o_empty  <= 1'b1;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      o_count  <= w_count_nxt;
      o_full   <= (w_count_nxt == CNT_W'(DEPTH));
      o_empty  <= (w_count_nxt == '0);
    end
  end

  // Record storage; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Command sequencer between the SPI word handler and the step generator.
// Parses 32-bit command words into configuration updates and move records,
// buffers moves, and dispatches them one at a time with a start/done handshake.
// Ports:
//   CLK, reset                 : clock, synchronous active-high reset
//   word_valid, word_data      : one received command word per pulse
//   move_busy, move_done       : step generator status / end-of-move pulse
//   move_start                 : one-cycle launch pulse
//   move_duration, increment,
//   incrementincrement, dir    : dispatched move, held until the next launch
//   clock_divisor, microsteps  : configuration registers
//   fifo_count                 : buffered moves
//   status                     : sticky {bad microstep, unknown header, overflow}
module move_sequencer
  import rap_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_RESET = 32
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       word_valid,
  input  logic [WORD_W-1:0]          word_data,
  input  logic                       move_busy,
  input  logic                       move_done,
  output logic                       move_start,
  output logic [WORD_W-1:0]          move_duration,
  output logic signed [WORD_W-1:0]   increment,
  output logic signed [WORD_W-1:0]   incrementincrement,
  output logic                       dir,
  output logic [DIV_W-1:0]           clock_divisor,
  output logic [USTEP_W-1:0]         microsteps,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [STATUS_W-1:0]        status
);

  parser_state_t      r_pstate;
  parser_state_t      w_pstate_nxt;
  disp_state_t        r_dstate;
  disp_state_t        w_dstate_nxt;

  logic               r_dir_lat;
  logic [WORD_W-1:0]  r_dur_lat;
  logic [WORD_W-1:0]  r_inc_lat;

  logic [HDR_W-1:0]   w_hdr;
  logic               w_lat_dir;
  logic               w_lat_dur;
  logic               w_lat_inc;
  logic               w_set_div;
  logic               w_set_ustep;
  logic               w_bad_ustep;
  logic               w_bad_hdr;
  logic               w_clr;
  logic               w_ovf;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_full;
  logic               w_empty;
  move_t              w_push_rec;
  move_t              w_head;

  assign w_hdr      = word_data[WORD_W-1 -: HDR_W];
  // The third payload word goes straight into the record being pushed
  assign w_push_rec = move_t'({r_dir_lat, r_dur_lat, r_inc_lat, word_data});

  // Parser: state register
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_pstate <= P_IDLE;
    end else begin
      r_pstate <= w_pstate_nxt;
    end
  end

  // Parser: header decode and payload sequencing
  always_comb begin
    w_pstate_nxt = r_pstate;
    w_lat_dir    = 1'b0;
    w_lat_dur    = 1'b0;
    w_lat_inc    = 1'b0;
    w_set_div    = 1'b0;
    w_set_ustep  = 1'b0;
    w_bad_ustep  = 1'b0;
    w_bad_hdr    = 1'b0;
    w_clr        = 1'b0;
    w_ovf        = 1'b0;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    if (word_valid) begin
      case (r_pstate)
        P_IDLE: begin
          case (w_hdr)
            HDR_MOVE: begin
              w_lat_dir    = 1'b1;
              w_pstate_nxt = P_1;
            end
            HDR_DIV:   w_set_div = 1'b1;
            HDR_USTEP: begin
              if (ustep_valid(word_data[USTEP_W-1:0])) begin
                w_set_ustep = 1'b1;
              end else begin
                w_bad_ustep = 1'b1;
              end
            end
            HDR_FLUSH: w_flush   = 1'b1;
            HDR_CLR:   w_clr     = 1'b1;
            default:   w_bad_hdr = 1'b1;
          endcase
        end
        P_1: begin
          w_lat_dur    = 1'b1;
          w_pstate_nxt = P_2;
        end
        P_2: begin
          w_lat_inc    = 1'b1;
          w_pstate_nxt = P_3;
        end
        P_3: begin
          w_push       = 1'b1;
          w_ovf        = w_full && !w_pop;
          w_pstate_nxt = P_IDLE;
        end
        default: w_pstate_nxt = P_IDLE;
      endcase
    end
  end

  // Parser datapath: payload latches, configuration and sticky status
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_dir_lat     <= 1'b0;
      r_dur_lat     <= '0;
      r_inc_lat     <= '0;
      clock_divisor <= DIV_W'(DIV_RESET);
      microsteps    <= USTEP_W'(1);
      status        <= '0;
    end else begin
      if (w_lat_dir)   r_dir_lat     <= word_data[0];
      if (w_lat_dur)   r_dur_lat     <= word_data;
      if (w_lat_inc)   r_inc_lat     <= word_data;
      if (w_set_div)   clock_divisor <= word_data[DIV_W-1:0];
      if (w_set_ustep) microsteps    <= word_data[USTEP_W-1:0];
      if (w_clr) begin
        status <= '0;
      end else begin
        status <= status | {w_bad_ustep, w_bad_hdr, w_ovf};
      end
    end
  end

  // Dispatcher: state register
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_dstate <= D_IDLE;
    end else begin
      r_dstate <= w_dstate_nxt;
    end
  end

  // Dispatcher: launch when a move is buffered and the generator is free
  always_comb begin
    w_dstate_nxt = r_dstate;
    w_pop        = 1'b0;
    case (r_dstate)
      D_IDLE: begin
        if (!w_empty && !move_busy) begin
          w_pop        = 1'b1;
          w_dstate_nxt = D_RUN;
        end
      end
      D_RUN: begin
        if (move_done) w_dstate_nxt = D_IDLE;
      end
      default: w_dstate_nxt = D_IDLE;
    endcase
  end

  // Move outputs load only on launch so they hold between moves
  always_ff @(posedge CLK) begin
    if (reset) begin
      move_start         <= 1'b0;
      dir                <= 1'b0;
      move_duration      <= '0;
      increment          <= '0;
      incrementincrement <= '0;
    end else begin
      move_start <= w_pop;
      if (w_pop) begin
        dir                <= w_head.dir;
        move_duration      <= w_head.duration;
        increment          <= w_head.inc;
        incrementincrement <= w_head.incinc;
      end
    end
  end

  move_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (CLK),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_wr_data   (w_push_rec),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_rd_data_c (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count)
  );

endmodule
